// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin grant, single outstanding access,
// byte-enable stores done as read-merge-write against a single-ported memory.
// Byte enables cover the low 32 bits; WORD_SIZE is expected to be >= 32.
module dmem_arbiter #(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  // requester 0
  input  logic                 i_req0,
  input  logic                 i_we0,
  input  logic [WORD_SIZE-1:0] i_addr0,
  input  logic [WORD_SIZE-1:0] i_wd0,
  input  logic [3:0]           i_be0,
  output logic                 o_gnt0,
  output logic                 o_rvalid0,
  output logic [WORD_SIZE-1:0] o_rd0,
  // requester 1
  input  logic                 i_req1,
  input  logic                 i_we1,
  input  logic [WORD_SIZE-1:0] i_addr1,
  input  logic [WORD_SIZE-1:0] i_wd1,
  input  logic [3:0]           i_be1,
  output logic                 o_gnt1,
  output logic                 o_rvalid1,
  output logic [WORD_SIZE-1:0] o_rd1,
  // memory side
  output logic [WORD_SIZE-1:0] o_mem_addr,
  output logic [WORD_SIZE-1:0] o_mem_wd,
  output logic                 o_mem_wen,
  output logic                 o_mem_ren,
  input  logic [WORD_SIZE-1:0] i_mem_rd,
  output logic                 o_busy
);

  localparam int unsigned BE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_MERGE_WR = 2'd2
  } state_e;

  state_e                 state_q;
  logic                   id_q;
  logic                   last_q;
  logic                   we_q;
  logic [BE_W-1:0]        be_q;
  logic [WORD_SIZE-1:0]   wd_q;
  logic [WORD_SIZE-1:0]   merge_q;

  logic                   rvalid0_q, rvalid1_q;
  logic [WORD_SIZE-1:0]   rd0_q, rd1_q;
  logic [WORD_SIZE-1:0]   mem_addr_q, mem_wd_q;
  logic                   mem_wen_q, mem_ren_q;
  logic                   busy_q;

  logic                   gnt0_c, gnt1_c, grant_c;
  logic                   sel_we_c;
  logic [BE_W-1:0]        sel_be_c;
  logic [WORD_SIZE-1:0]   sel_addr_c, sel_wd_c, word_addr_c;
  logic [WORD_SIZE-1:0]   merged_c;
  logic                   partial_c;
  logic                   unused_addr_lsbs;

  // Round-robin grant, only while idle and out of reset; tie goes to the requester not served last
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (i_rst_n && (state_q == ST_IDLE)) begin
      if (i_req0 && i_req1) begin
        if (last_q) gnt0_c = 1'b1;
        else        gnt1_c = 1'b1;
      end else if (i_req0) begin
        gnt0_c = 1'b1;
      end else if (i_req1) begin
        gnt1_c = 1'b1;
      end
    end
  end

  // Fields of whichever requester is being granted
  always_comb begin
    grant_c     = gnt0_c | gnt1_c;
    sel_we_c    = gnt1_c ? i_we1   : i_we0;
    sel_be_c    = gnt1_c ? i_be1   : i_be0;
    sel_addr_c  = gnt1_c ? i_addr1 : i_addr0;
    sel_wd_c    = gnt1_c ? i_wd1   : i_wd0;
    word_addr_c = {sel_addr_c[WORD_SIZE-1:2], 2'b00};
  end

  // Byte offset bits never reach the memory
  assign unused_addr_lsbs = ^sel_addr_c[1:0];

  // Merge enabled store bytes over the word currently read from memory
  always_comb begin
    merged_c  = i_mem_rd;
    partial_c = (be_q != 4'h0) && (be_q != 4'hF);
    for (int unsigned k = 0; k < BE_W; k++) begin
      if (be_q[k]) merged_c[8*k +: 8] = wd_q[8*k +: 8];
    end
  end

  // Access state machine with registered memory-side and completion outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      id_q       <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      be_q       <= '0;
      wd_q       <= '0;
      merge_q    <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rd0_q      <= '0;
      rd1_q      <= '0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      mem_wen_q  <= 1'b0;
      mem_ren_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_c) begin
            id_q       <= gnt1_c;
            last_q     <= gnt1_c;
            we_q       <= sel_we_c;
            be_q       <= sel_be_c;
            wd_q       <= sel_wd_c;
            mem_addr_q <= word_addr_c;
            busy_q     <= 1'b1;
            state_q    <= ST_ACCESS;
            if (!sel_we_c) begin
              mem_ren_q <= 1'b1;
            end else if (sel_be_c == 4'hF) begin
              mem_wen_q <= 1'b1;
              mem_wd_q  <= sel_wd_c;
            end else if (sel_be_c != 4'h0) begin
              mem_ren_q <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          mem_ren_q <= 1'b0;
          if (we_q && partial_c) begin
            merge_q   <= merged_c;
            mem_wd_q  <= merged_c;
            mem_wen_q <= 1'b1;
            state_q   <= ST_MERGE_WR;
          end else begin
            if (!we_q) begin
              if (id_q) rd1_q <= i_mem_rd;
              else      rd0_q <= i_mem_rd;
            end
            if (id_q) rvalid1_q <= 1'b1;
            else      rvalid0_q <= 1'b1;
            mem_wen_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        ST_MERGE_WR: begin
          if (id_q) rvalid1_q <= 1'b1;
          else      rvalid0_q <= 1'b1;
          mem_wen_q  <= 1'b0;
          mem_addr_q <= '0;
          mem_wd_q   <= '0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_gnt0     = gnt0_c;
  assign o_gnt1     = gnt1_c;
  assign o_rvalid0  = rvalid0_q;
  assign o_rvalid1  = rvalid1_q;
  assign o_rd0      = rd0_q;
  assign o_rd1      = rd1_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_wd   = mem_wd_q;
  assign o_mem_wen  = mem_wen_q;
  assign o_mem_ren  = mem_ren_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a transaction-level model predicts every
// output each cycle; directed scenarios add hand-computed literal checks.
module tb_dmem_arbiter;

  localparam int NC = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wd0, addr1, wd1;
  logic [3:0]  be0, be1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rd0, rd1;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_wen, mem_ren, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  dmem_arbiter #(.WORD_SIZE(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wd0(wd0), .i_be0(be0),
    .o_gnt0(gnt0), .o_rvalid0(rvalid0), .o_rd0(rd0),
    .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wd1(wd1), .i_be1(be1),
    .o_gnt1(gnt1), .o_rvalid1(rvalid1), .o_rd1(rd1),
    .o_mem_addr(mem_addr), .o_mem_wd(mem_wd), .o_mem_wen(mem_wen),
    .o_mem_ren(mem_ren), .i_mem_rd(mem_rd), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4 || i == 8) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Memory behind the arbiter: combinational read, write on clock edge
  logic [31:0] mem [16];
  bit          mem_ready;
  assign mem_rd = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (rst_n && mem_wen) begin
      mem[mem_addr[5:2]] <= mem_wd;
    end
  end

  // ---------------- transaction-level model ----------------
  bit          e_ren [NC];
  bit          e_wen [NC];
  bit          e_rv0 [NC];
  bit          e_rv1 [NC];
  bit          e_ld  [NC];
  bit          e_ldid[NC];
  logic [31:0] e_addr[NC];
  logic [31:0] e_wd  [NC];
  logic [31:0] e_ldv [NC];
  int          e_widx[NC];

  logic [31:0] mmem [16];
  bit          mmem_ready;
  int          free_at;
  bit          last1;
  logic [31:0] rd0_m, rd1_m;
  bit          m_g0, m_g1, m_busy, m_n, m_we;
  logic [31:0] m_addr, m_wd, m_mask, m_word;
  logic [3:0]  m_be;
  int          m_idx, m_done, c;

  always @(negedge clk) begin
    c = cyc;
    if (!mmem_ready) begin
      for (int i = 0; i < 16; i++) mmem[i] = init_word(i);
      mmem_ready = 1'b1;
    end
    if (!rst_n) begin
      for (int j = c; j < NC; j++) begin
        e_ren[j] = 0; e_wen[j] = 0; e_rv0[j] = 0; e_rv1[j] = 0; e_ld[j] = 0;
        e_ldid[j] = 0; e_addr[j] = '0; e_wd[j] = '0; e_ldv[j] = '0; e_widx[j] = 0;
      end
      last1 = 1'b1; free_at = c; rd0_m = '0; rd1_m = '0;
      chk1("rst_gnt0", gnt0, 1'b0);     chk1("rst_gnt1", gnt1, 1'b0);
      chk1("rst_rvalid0", rvalid0, 1'b0); chk1("rst_rvalid1", rvalid1, 1'b0);
      chk1("rst_wen", mem_wen, 1'b0);   chk1("rst_ren", mem_ren, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk("rst_addr", mem_addr, '0);    chk("rst_wd", mem_wd, '0);
      chk("rst_rd0", rd0, '0);          chk("rst_rd1", rd1, '0);
    end else if (c + 4 < NC) begin
      m_busy = (c < free_at);
      if (e_ld[c]) begin
        if (e_ldid[c]) rd1_m = e_ldv[c];
        else           rd0_m = e_ldv[c];
      end
      if (e_wen[c]) mmem[e_widx[c]] = e_wd[c];
      m_g0 = 0; m_g1 = 0;
      if (!m_busy) begin
        if (req0 && req1) begin
          if (last1) m_g0 = 1; else m_g1 = 1;
        end else if (req0) m_g0 = 1;
        else if (req1) m_g1 = 1;
      end
      if (m_g0 || m_g1) begin
        m_n    = m_g1;
        m_we   = m_n ? we1 : we0;
        m_addr = (m_n ? addr1 : addr0) & 32'hFFFF_FFFC;
        m_wd   = m_n ? wd1 : wd0;
        m_be   = m_n ? be1 : be0;
        m_idx  = int'(m_addr[5:2]);
        e_addr[c+1] = m_addr;
        m_done = c + 2;
        if (!m_we) begin
          e_ren[c+1] = 1;
          e_ld[c+2] = 1; e_ldid[c+2] = m_n; e_ldv[c+2] = mmem[m_idx];
        end else if (m_be == 4'hF) begin
          e_wen[c+1] = 1; e_wd[c+1] = m_wd; e_widx[c+1] = m_idx;
        end else if (m_be != 4'h0) begin
          m_mask = {{8{m_be[3]}}, {8{m_be[2]}}, {8{m_be[1]}}, {8{m_be[0]}}};
          m_word = (m_wd & m_mask) | (mmem[m_idx] & ~m_mask);
          e_ren[c+1] = 1;
          e_addr[c+2] = m_addr;
          e_wen[c+2] = 1; e_wd[c+2] = m_word; e_widx[c+2] = m_idx;
          m_done = c + 3;
        end
        if (m_n) e_rv1[m_done] = 1; else e_rv0[m_done] = 1;
        free_at = m_done;
        last1 = m_n;
      end
      chk1("gnt0", gnt0, m_g0);         chk1("gnt1", gnt1, m_g1);
      chk1("ren", mem_ren, e_ren[c]);   chk1("wen", mem_wen, e_wen[c]);
      chk("mem_addr", mem_addr, e_addr[c]);
      if (e_wen[c]) chk("mem_wd", mem_wd, e_wd[c]);
      chk1("rvalid0", rvalid0, e_rv0[c]); chk1("rvalid1", rvalid1, e_rv1[c]);
      chk1("busy", busy, m_busy);
      chk("rd0", rd0, rd0_m);           chk("rd1", rd1, rd1_m);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input bit n, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (n) begin we1 = we; addr1 = addr; wd1 = wd; be1 = be; req1 = 1'b1; end
    else   begin we0 = we; addr0 = addr; wd0 = wd; be0 = be; req0 = 1'b1; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = n ? gnt1 : gnt0;
    end
    chk1("grant_wait", got, 1'b1);
  endtask

  task automatic drop();
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  int ord[4];
  int nord;

  initial begin
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wd0 = '0; be0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wd1 = '0; be1 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Load from 0x10 by requester 0: grant T, ren T+1, rvalid T+2
    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
    drop();
    @(negedge clk); chk1("A_ren", mem_ren, 1'b1); chk("A_addr", mem_addr, 32'h10);
    @(negedge clk); chk1("A_rvalid0", rvalid0, 1'b1); chk("A_rd0", rd0, 32'hDEADBEEF);

    // Partial store: byte 1 of 0xDEADBEEF replaced by 0xAB
    issue(1'b1, 1'b1, 32'h22, 32'h0000AB00, 4'b0010);
    drop();
    @(negedge clk); chk1("B_ren", mem_ren, 1'b1); chk1("B_wen0", mem_wen, 1'b0);
                    chk("B_addr_rd", mem_addr, 32'h20);
    @(negedge clk); chk1("B_wen", mem_wen, 1'b1); chk1("B_ren0", mem_ren, 1'b0);
                    chk("B_addr_wr", mem_addr, 32'h20); chk("B_wd", mem_wd, 32'hDEADABEF);
    @(negedge clk); chk1("B_rvalid1", rvalid1, 1'b1); chk1("B_wen_off", mem_wen, 1'b0);

    // Full-word store by requester 1
    issue(1'b1, 1'b1, 32'h20, 32'h11223344, 4'hF);
    drop();
    @(negedge clk); chk1("C_wen", mem_wen, 1'b1); chk1("C_ren", mem_ren, 1'b0);
                    chk("C_addr", mem_addr, 32'h20); chk("C_wd", mem_wd, 32'h11223344);
    @(negedge clk); chk1("C_rvalid1", rvalid1, 1'b1); chk1("C_wen_single", mem_wen, 1'b0);

    // Store with no byte enables: no write, completes 2 cycles after grant
    issue(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
    drop();
    @(negedge clk); chk1("D_wen", mem_wen, 1'b0); chk1("D_ren", mem_ren, 1'b0);
                    chk1("D_busy", busy, 1'b1);
    @(negedge clk); chk1("D_rvalid0", rvalid0, 1'b1); chk1("D_wen2", mem_wen, 1'b0);
                    chk("D_rd0_held", rd0, 32'hDEADBEEF);

    // Read back 0x20 via requester 1
    issue(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    drop();
    @(negedge clk);
    @(negedge clk); chk1("E_rvalid1", rvalid1, 1'b1); chk("E_rd1", rd1, 32'h11223344);
                    chk("E_rd0", rd0, 32'hDEADBEEF);

    // Both requesters held continuously: expect 0,1,0,1
    @(posedge clk); #1;
    we0 = 0; addr0 = 32'h10; be0 = 4'hF;
    we1 = 0; addr1 = 32'h20; be1 = 4'hF;
    req0 = 1; req1 = 1;
    nord = 0;
    for (int i = 0; i < 40 && nord < 4; i++) begin
      @(negedge clk);
      chk1("F_not_both", gnt0 & gnt1, 1'b0);
      if (gnt0 && nord < 4) begin ord[nord] = 0; nord++; end
      if (gnt1 && nord < 4) begin ord[nord] = 1; nord++; end
    end
    drop();
    chk("F_count", 32'(nord), 32'd4);
    chk("F_ord0", 32'(ord[0]), 32'd0); chk("F_ord1", 32'(ord[1]), 32'd1);
    chk("F_ord2", 32'(ord[2]), 32'd0); chk("F_ord3", 32'(ord[3]), 32'd1);
    repeat (4) @(posedge clk);

    // Reset pulsed during the merge-write cycle of a partial store to 0x24
    issue(1'b0, 1'b1, 32'h24, 32'h000000AA, 4'b0001);
    drop();
    @(posedge clk); #1;
    chk1("G_in_merge", mem_wen, 1'b1);
    rst_n = 1'b0;
    @(negedge clk); chk1("G_wen", mem_wen, 1'b0); chk1("G_busy", busy, 1'b0);
                    chk("G_addr", mem_addr, 32'h0); chk("G_wd", mem_wd, 32'h0);
                    chk("G_rd0", rd0, 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk); chk1("G_no_rvalid", rvalid0, 1'b0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("G_mem_untouched", mem[9], 32'h10000009);
                    chk1("G_no_rvalid_after", rvalid0, 1'b0);
    @(posedge clk); #1;
    we0 = 0; addr0 = 32'h10; we1 = 0; addr1 = 32'h20;
    req0 = 1; req1 = 1;
    @(negedge clk); chk1("G_tie_gnt0", gnt0, 1'b1); chk1("G_tie_gnt1", gnt1, 1'b0);
    drop();
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have the parameter WORD_SIZE, default 32, giving the data and address width in bits.
REQ-002 The block SHALL have the port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have, for N in {0,1}, the ports i_reqN  input  1  access request; i_weN  input  1  1=store, 0=load; i_addrN  input  WORD_SIZE  byte address; i_wdN  input  WORD_SIZE  store data; i_beN  input  4  byte enables, bit k covering bits [8k+7:8k].
REQ-005 The block SHALL have, for N in {0,1}, the ports o_gntN  output  1  request accepted; o_rvalidN  output  1  completion pulse; o_rdN  output  WORD_SIZE  load data.
REQ-006 The block SHALL have the memory-side ports o_mem_addr  output  WORD_SIZE; o_mem_wd  output  WORD_SIZE; o_mem_wen  output  1; o_mem_ren  output  1; i_mem_rd  input  WORD_SIZE, which is combinational read data valid in the same cycle as o_mem_addr.
REQ-007 The block SHALL have the port o_busy  output  1, high whenever the state is not IDLE.

Function
REQ-008 The state machine SHALL have exactly three states, IDLE, ACCESS and MERGE_WR; it SHALL leave IDLE only on a grant, and SHALL return to IDLE after ACCESS or MERGE_WR completes.
REQ-009 In IDLE with at least one i_reqN high, the block SHALL assert the matching o_gntN combinationally for that cycle only, latch that requester's we/addr/wd/be and its id, and go to ACCESS.
REQ-010 Arbitration SHALL be round-robin: a lone requester is granted; when both request, the requester not granted last time wins; after reset, requester 0 wins the first tie.
REQ-011 Requesters SHALL hold req and all fields stable until gnt; fields are sampled only in the grant cycle; a req dropped before gnt SHALL have no effect.
REQ-012 No grant SHALL be issued outside IDLE; o_gnt0 and o_gnt1 SHALL never be high together.
REQ-013 o_mem_addr SHALL equal {latched addr[WORD_SIZE-1:2], 2'b00} in ACCESS and MERGE_WR, and 0 in IDLE; addr[1:0] SHALL be ignored.
REQ-014 In ACCESS for a load, the block SHALL set o_mem_ren=1, register i_mem_rd into o_rdN of the latched requester, pulse o_rvalidN the following cycle, and go to IDLE; load latency from grant to o_rvalidN SHALL be 2 cycles.
REQ-015 In ACCESS for a store with be=4'hF, the block SHALL set o_mem_wen=1 and o_mem_wd=latched wd, pulse o_rvalidN the following cycle, and go to IDLE.
REQ-016 In ACCESS for a store with a be other than 4'hF or 4'h0, the block SHALL set o_mem_ren=1, register the merged word (byte k from wd if be[k], otherwise from i_mem_rd), and go to MERGE_WR.
REQ-017 In MERGE_WR, the block SHALL set o_mem_wen=1 and o_mem_wd=merged word, pulse o_rvalidN the following cycle, and go to IDLE.
REQ-018 A store with be=4'h0 SHALL produce no memory write and complete like a full-word store.
REQ-019 o_rvalidN SHALL be a single-cycle pulse; o_rdN SHALL hold its last load value and SHALL be unchanged by stores.
REQ-020 o_mem_wen and o_mem_ren SHALL never be high together, and SHALL both be low in IDLE.
REQ-021 A new grant SHALL be possible in the same cycle as the previous o_rvalidN pulse, since the state is then IDLE.

Reset
REQ-022 While i_rst_n=0, the block SHALL immediately hold state IDLE, all o_gntN/o_rvalidN/o_mem_wen/o_mem_ren/o_busy at 0, o_rdN/o_mem_addr/o_mem_wd at 0, the merge register at 0, and the round-robin pointer at "requester 1 last".
REQ-023 A reset asserted mid-operation SHALL abort that operation, with no memory write and no o_rvalidN pulse issued for it after reset.

Verification
REQ-024 The bench SHALL cover: req0 load addr 0x10 with memory word 0xDEADBEEF -> gnt0 in cycle T, ren in T+1, o_rvalid0 in T+2 with o_rd0=0xDEADBEEF.
REQ-025 The bench SHALL cover: req1 store addr 0x20, wd 0x11223344, be 4'hF -> single wen cycle with o_mem_addr=0x20 and o_mem_wd=0x11223344, then o_rvalid1.
REQ-026 The bench SHALL cover: store addr 0x22, wd 0x0000AB00, be 4'b0010 over memory word 0xDEADBEEF -> ren cycle, then wen with o_mem_addr=0x20 and o_mem_wd=0xDEADABEF.
REQ-027 The bench SHALL cover: req0 and req1 held continuously for 4 grants -> order 0,1,0,1, each grant one cycle, never simultaneous.
REQ-028 The bench SHALL cover: reset pulsed during the MERGE_WR state -> no wen, no rvalid, outputs 0, and after release a tie grants requester 0.
REQ-029 The bench SHALL cover: store with be=4'h0 -> no wen, o_rvalidN asserted 2 cycles after grant.
